i2c_master_writer: RTL and testbench

//  I2C master that writes a 3-byte frame to the register-file slave: START, {SLAVE_ADDR,W},

---
 rtl/i2c_master_writer.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_master_writer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/i2c_master_writer.sv
// I2C master that writes {SLAVE_ADDR,W}, reg_addr, wr_data framed by START/STOP on open-drain lines.
// Optional feature macro: I2C_MASTER_RETRY_EN (one retry of the whole frame after an address NACK).
module i2c_master_writer #(
  parameter int       CLK_DIV    = 4,
  parameter bit [6:0] SLAVE_ADDR = 7'h47
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    WAIT  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    ra_q, ra_d;
  logic [7:0]    wd_q, wd_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;
`ifdef I2C_MASTER_RETRY_EN
  logic          retried_q, retried_d;
  logic          retry_pend_q, retry_pend_d;
`endif
  logic          qtick_s;
  logic          last_s;
  logic [7:0]    cur_byte_s;
  logic [1:0]    drive_s;

  // Line drive {scl_oe, sda_oe} for a given state/phase; computed on next-state values so outputs are flops.
  function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] ph, input logic bitv);
    logic [1:0] r;
    r = 2'b00;
    case (st)
      START:   r = (ph == 2'd2) ? 2'b01 : ((ph == 2'd3) ? 2'b11 : 2'b00);
      BIT:     r = {(ph < 2'd2), ~bitv};
      ACK:     r = {(ph < 2'd2), 1'b0};
      STOP:    r = (ph == 2'd0) ? 2'b11 : ((ph == 2'd1) ? 2'b01 : 2'b00);
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  assign qtick_s = (qcnt_q == Q_LAST);
  assign last_s  = qtick_s && (phase_q == 2'd3);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    ra_d     = ra_q;
    wd_d     = wd_q;
    ack_d    = ack_q;
    nack_d   = nack_q;
`ifdef I2C_MASTER_RETRY_EN
    retried_d    = retried_q;
    retry_pend_d = retry_pend_q;
`endif
    if (state_q == IDLE) begin
      qcnt_d  = '0;
      phase_d = 2'd0;
    end else begin
      qcnt_d  = qtick_s ? '0 : qcnt_q + QW'(1);
      phase_d = qtick_s ? phase_q + 2'd1 : phase_q;
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = START;
          ra_d    = reg_addr;
          wd_d    = wr_data;
          nack_d  = 1'b0;
          bit_d   = 3'd7;
          byte_d  = 2'd0;
`ifdef I2C_MASTER_RETRY_EN
          retried_d    = 1'b0;
          retry_pend_d = 1'b0;
`endif
        end
      end
      START: begin
        if (last_s) begin
          state_d = BIT;
          bit_d   = 3'd7;
          byte_d  = 2'd0;
        end
      end
      BIT: begin
        if (last_s) begin
          if (bit_q == 3'd0) begin
            state_d = ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ACK: begin
        // Slave's answer is taken on the final clk of q2, mid SCL-high.
        if (qtick_s && (phase_q == 2'd2)) begin
          ack_d = sda_i;
        end
        if (last_s) begin
          if (ack_q) begin
            state_d = STOP;
`ifdef I2C_MASTER_RETRY_EN
            if ((byte_q == 2'd0) && !retried_q) begin
              retry_pend_d = 1'b1;
            end else begin
              nack_d = 1'b1;
            end
`else
            nack_d = 1'b1;
`endif
          end else if (byte_q == 2'd2) begin
            state_d = STOP;
          end else begin
            state_d = BIT;
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd7;
          end
        end
      end
      STOP: begin
        if (last_s) begin
`ifdef I2C_MASTER_RETRY_EN
          state_d = retry_pend_q ? WAIT : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef I2C_MASTER_RETRY_EN
      WAIT: begin
        if (last_s) begin
          state_d      = START;
          retried_d    = 1'b1;
          retry_pend_d = 1'b0;
          bit_d        = 3'd7;
          byte_d       = 2'd0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    case (byte_d)
      2'd0:    cur_byte_s = {SLAVE_ADDR, 1'b0};
      2'd1:    cur_byte_s = ra_q;
      default: cur_byte_s = wd_q;
    endcase
    drive_s  = line_drive(state_d, phase_d, cur_byte_s[bit_d]);
    scl_oe_d = drive_s[1];
    sda_oe_d = drive_s[0];
    busy_d   = (state_d != IDLE);
`ifdef I2C_MASTER_RETRY_EN
    done_d   = (state_d == STOP) && (phase_d == 2'd3) && (qcnt_d == Q_LAST) && !retry_pend_d;
`else
    done_d   = (state_d == STOP) && (phase_d == 2'd3) && (qcnt_d == Q_LAST);
`endif
  end

  // State and registered outputs; reset releases both lines at once without a STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      qcnt_q   <= '0;
      phase_q  <= 2'd0;
      bit_q    <= 3'd0;
      byte_q   <= 2'd0;
      ra_q     <= 8'h00;
      wd_q     <= 8'h00;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
`ifdef I2C_MASTER_RETRY_EN
      retried_q    <= 1'b0;
      retry_pend_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      ra_q     <= ra_d;
      wd_q     <= wd_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
`ifdef I2C_MASTER_RETRY_EN
      retried_q    <= retried_d;
      retry_pend_q <= retry_pend_d;
`endif
    end
  end

  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign nack   = nack_q;

endmodule

// File: tb/tb_i2c_master_writer.sv
// Directed bench for i2c_master_writer: bus monitor + ACK/NACK slave model, checks bytes, timing, flags.
module tb_i2c_master_writer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       sda_i;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       nack;
  logic       slave_pull;

  int checks = 0;
  int errors = 0;

  // monitor state
  logic       prev_scl, prev_sda, scl_l, sda_l;
  logic [7:0] cur;
  logic [7:0] byte_log [0:2];
  int         bitpos, starts, glitches, nbytes, done_cnt, busy_cnt, nack_at;

  assign sda_i = ~(sda_oe | slave_pull);

  i2c_master_writer #(.CLK_DIV(D), .SLAVE_ADDR(7'h47)) dut (
    .clk(clk), .rst(rst), .req(req), .reg_addr(reg_addr), .wr_data(wr_data),
    .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy), .done(done), .nack(nack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    bitpos = 0; starts = 0; glitches = 0; nbytes = 0; done_cnt = 0; busy_cnt = 0;
    prev_scl = 1'b1; prev_sda = 1'b1; slave_pull = 1'b0; cur = 8'h00;
    for (int i = 0; i < 3; i++) byte_log[i] = 8'h00;
  endtask

  // Bus monitor and slave: capture bits on SCL rise, drive ACK after SCL fall, flag SDA edges with SCL high.
  always @(negedge clk) begin
    scl_l = ~scl_oe;
    sda_l = ~(sda_oe | slave_pull);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (scl_l && prev_scl && (sda_l != prev_sda)) begin
      glitches++;
      if (!sda_l) begin
        starts++;
        bitpos = 0;
        nbytes = 0;
      end
    end else if (scl_l && !prev_scl) begin
      if ((bitpos % 9) < 8) begin
        cur = {cur[6:0], sda_l};
        if (((bitpos % 9) == 7) && ((bitpos / 9) < 3)) begin
          byte_log[bitpos / 9] = cur;
          nbytes++;
        end
      end
      bitpos++;
    end else if (!scl_l && prev_scl) begin
      if ((bitpos % 9) == 8) slave_pull = !((starts == 1) && ((bitpos / 9) == nack_at));
      else slave_pull = 1'b0;
    end
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  task automatic run_frame(input logic [7:0] ra, input logic [7:0] wd, input int nk,
                           input int exp_busy, input logic exp_nack, input int exp_starts,
                           input int exp_bytes, input logic flood, input string tag);
    int n;
    @(negedge clk);
    clear_mon();
    nack_at = nk; reg_addr = ra; wr_data = wd; req = 1'b1;
    @(negedge clk);
    chk($sformatf("%s.busy_rise", tag), busy, 1'b1);
    chk($sformatf("%s.nack_clr", tag), nack, 1'b0);
    if (flood) begin
      reg_addr = 8'hFF; wr_data = 8'h00;
    end else begin
      req = 1'b0;
    end
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    chk($sformatf("%s.timeout", tag), (n < 3000), 1'b1);
    repeat (3) @(negedge clk);
    chk($sformatf("%s.busy_cycles", tag), busy_cnt, exp_busy);
    chk($sformatf("%s.done_pulses", tag), done_cnt, 1);
    chk($sformatf("%s.nack", tag), nack, exp_nack);
    chk($sformatf("%s.starts", tag), starts, exp_starts);
    chk($sformatf("%s.scl_high_sda_edges", tag), glitches, 2 * exp_starts);
    chk($sformatf("%s.nbytes", tag), nbytes, exp_bytes);
    chk($sformatf("%s.byte0", tag), byte_log[0], 8'h8E);
    if (exp_bytes >= 2) chk($sformatf("%s.byte1", tag), byte_log[1], ra);
    if (exp_bytes >= 3) chk($sformatf("%s.byte2", tag), byte_log[2], wd);
    chk($sformatf("%s.idle_after", tag), busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; reg_addr = 8'h00; wr_data = 8'h00; nack_at = -1;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst.scl_oe", scl_oe, 1'b0);
    chk("rst.sda_oe", sda_oe, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.nack", nack, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1: all ACKed, 116*D busy cycles
    run_frame(8'h03, 8'hA5, -1, 116 * D, 1'b0, 1, 3, 1'b0, "t1");
    // T2: address NACK
`ifdef I2C_MASTER_RETRY_EN
    run_frame(8'h5A, 8'h3C, 0, (11 + 1 + 29) * 4 * D, 1'b0, 2, 3, 1'b0, "t2");
`else
    run_frame(8'h5A, 8'h3C, 0, (2 + 9) * 4 * D, 1'b1, 1, 1, 1'b0, "t2");
`endif
    // NACK on register byte, then on data byte
    run_frame(8'h96, 8'h69, 1, (2 + 18) * 4 * D, 1'b1, 1, 2, 1'b0, "t2b");
    run_frame(8'hC1, 8'h7E, 2, 116 * D, 1'b1, 1, 3, 1'b0, "t3");
    // T4: req held every cycle with changing inputs -> one frame of the first inputs
    run_frame(8'h5C, 8'hE2, -1, 116 * D, 1'b0, 1, 3, 1'b1, "t4");

    // T5: reset in q0 of bit 1 of the address byte (SCL low, SDA low)
    @(negedge clk);
    clear_mon();
    reg_addr = 8'h11; wr_data = 8'h22; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (34) @(negedge clk);
    chk("t5.pre_scl_oe", scl_oe, 1'b1);
    chk("t5.pre_sda_oe", sda_oe, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t5.scl_oe", scl_oe, 1'b0);
    chk("t5.sda_oe", sda_oe, 1'b0);
    chk("t5.busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(8'h0F, 8'h81, -1, 116 * D, 1'b0, 1, 3, 1'b0, "t5post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
